// File: rtl/w0rm_bus_controller.sv
// ---------------------------------------------------------------------------
// w0rm_bus_controller: routes CPU data accesses to RAM or the peripheral bus.
// Optional watchdog: W0RM_BUS_CONTROLLER_WATCHDOG_EN.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module w0rm_bus_controller #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] RAM_MASK       = 32'hFFFF_F000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE    = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_MASK    = 32'hFFFF_FF00,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  core_clk,
  input  logic                  reset_n,
  input  logic                  mem_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_fault_o,
  output logic                  mem_busy_o,
  output logic                  ram_valid_o,
  output logic                  ram_read_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic                  ram_valid_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  periph_valid_o,
  output logic                  periph_read_o,
  output logic                  periph_write_o,
  output logic [ADDR_WIDTH-1:0] periph_addr_o,
  output logic [DATA_WIDTH-1:0] periph_data_o,
  input  logic                  periph_valid_i,
  input  logic [DATA_WIDTH-1:0] periph_data_i
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] RAM_WAIT    = 2'd1;
  localparam logic [1:0] PERIPH_WAIT = 2'd2;
  localparam logic [1:0] FAULT       = 2'd3;

  logic [1:0]            state, next_state;
  logic                  req_read;
  logic                  in_wait, rsp, timeout;
  logic                  bad_req, hit_ram, hit_periph;
  logic                  accept, ram_strobe, periph_strobe;
  logic                  rsp_valid, rsp_fault;
  logic [DATA_WIDTH-1:0] rsp_data;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    bad_req    = (mem_read_i == mem_write_i) || (mem_addr_i[1:0] != 2'b00);
    hit_ram    = (mem_addr_i & RAM_MASK) == RAM_BASE;
    hit_periph = (mem_addr_i & PERIPH_MASK) == PERIPH_BASE;
    accept     = (state == IDLE) && mem_valid_i;
    in_wait    = (state == RAM_WAIT) || (state == PERIPH_WAIT);
    rsp        = ((state == RAM_WAIT) && ram_valid_i) ||
                 ((state == PERIPH_WAIT) && periph_valid_i);
  end

`ifdef W0RM_BUS_CONTROLLER_WATCHDOG_EN
  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_count;

  // Held at zero outside the WAIT states, so the first WAIT cycle sees 0.
  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n)     wd_count <= '0;
    else if (in_wait) wd_count <= wd_count + WD_W'(1);
    else              wd_count <= '0;
  end

  assign timeout = in_wait && (wd_count == WD_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_valid_i) begin
          if (bad_req)         next_state = FAULT;
          else if (hit_ram)    next_state = RAM_WAIT;
          else if (hit_periph) next_state = PERIPH_WAIT;
          else                 next_state = FAULT;
        end
      end
      RAM_WAIT:    if (ram_valid_i || timeout)    next_state = IDLE;
      PERIPH_WAIT: if (periph_valid_i || timeout) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // A real response takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    ram_strobe    = accept && (next_state == RAM_WAIT);
    periph_strobe = accept && (next_state == PERIPH_WAIT);
    rsp_valid     = (accept && (next_state == FAULT)) || rsp || timeout;
    rsp_fault     = (accept && (next_state == FAULT)) || (timeout && !rsp);
    rsp_data      = mem_data_o;
    if (rsp_valid) begin
      rsp_data = '0;
      if (rsp && req_read)
        rsp_data = (state == RAM_WAIT) ? ram_data_i : periph_data_i;
    end
  end

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      req_read       <= 1'b0;
      mem_valid_o    <= 1'b0;
      mem_fault_o    <= 1'b0;
      mem_data_o     <= '0;
      mem_busy_o     <= 1'b0;
      ram_valid_o    <= 1'b0;
      ram_read_o     <= 1'b0;
      ram_write_o    <= 1'b0;
      ram_addr_o     <= '0;
      ram_data_o     <= '0;
      periph_valid_o <= 1'b0;
      periph_read_o  <= 1'b0;
      periph_write_o <= 1'b0;
      periph_addr_o  <= '0;
      periph_data_o  <= '0;
    end else begin
      if (accept) req_read <= mem_read_i;
      mem_valid_o    <= rsp_valid;
      mem_fault_o    <= rsp_fault;
      mem_data_o     <= rsp_data;
      mem_busy_o     <= (next_state != IDLE);
      ram_valid_o    <= ram_strobe;
      ram_read_o     <= ram_strobe && mem_read_i;
      ram_write_o    <= ram_strobe && mem_write_i;
      periph_valid_o <= periph_strobe;
      periph_read_o  <= periph_strobe && mem_read_i;
      periph_write_o <= periph_strobe && mem_write_i;
      if (ram_strobe) begin
        ram_addr_o <= mem_addr_i;
        ram_data_o <= mem_data_i;
      end
      if (periph_strobe) begin
        periph_addr_o <= mem_addr_i;
        periph_data_o <= mem_data_i;
      end
    end
  end

endmodule

`default_nettype wire
